// File: rtl/regfile_multiport.sv
// regfile_multiport
// Parametrised integer register file for the ID stage. It has NUM_READ
// combinational read ports and NUM_WRITE write ports. It supports an
// optional write-to-read bypass and an optional hard-wired zero register.
// A per-register pending-write scoreboard lets decode detect RAW hazards.
// When several write ports hit the same register in one cycle, the
// highest-indexed port wins. This holds for both the stored value and the
// bypassed value.
module regfile_multiport #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   address,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read,
  output logic [NUM_READ-1:0]              busy,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  addressw,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  writeData,
  input  logic [NUM_WRITE-1:0]             writeEn,
  input  logic                             reserveEn,
  input  logic [ADDR_WIDTH-1:0]            reserveAddr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Architectural state: register contents and the pending-write flags.
  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]      busy_r;

  // Per-register decode of this cycle's write ports and reserve port.
  logic [DEPTH-1:0]      write_hit_s;
  logic [DATA_WIDTH-1:0] write_val_s [DEPTH];
  logic [DEPTH-1:0]      reserve_hit_s;

  // True when idx names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == {ADDR_WIDTH{1'b0}});
  endfunction

  // Resolve which register each write port updates. Later ports override
  // earlier ones, so the highest index wins.
  always_comb begin
    logic                  hit;
    logic                  match;
    logic [DATA_WIDTH-1:0] val;
    hit   = 1'b0;
    match = 1'b0;
    val   = {DATA_WIDTH{1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      hit = 1'b0;
      val = regs_r[r];
      for (int j = 0; j < NUM_WRITE; j++) begin
        match = writeEn[j]
              && (addressw[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
              && !is_zero_reg(ADDR_WIDTH'(r));
        hit   = hit | match;
        val   = match ? writeData[j*DATA_WIDTH +: DATA_WIDTH] : val;
      end
      write_hit_s[r] = hit;
      write_val_s[r] = val;
    end
  end

  // Decode the issue-time reserve. The zero register is never reserved.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      reserve_hit_s[r] = reserveEn
                       && (reserveAddr == ADDR_WIDTH'(r))
                       && !is_zero_reg(ADDR_WIDTH'(r));
    end
  end

  // Update register contents on write.
  // Each scoreboard flag goes PENDING on reserve and returns to IDLE on write.
  // A same-cycle reserve beats the write, because the newly issued
  // instruction still owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_r[r] <= {DATA_WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (write_hit_s[r]) begin
          regs_r[r] <= write_val_s[r];
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
      busy_r <= reserve_hit_s | (busy_r & ~write_hit_s);
    end
  end

  // Combinational read ports with optional bypass of same-cycle writes.
  // A bypassed read clears busy unless the register is also being
  // re-reserved this cycle.
  // Outputs are held at zero while reset is asserted.
  always_comb begin
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rval;
    logic                  byp;
    logic                  match;
    logic                  rbusy;
    logic                  force_zero;
    read       = {(NUM_READ*DATA_WIDTH){1'b0}};
    busy       = {NUM_READ{1'b0}};
    raddr      = {ADDR_WIDTH{1'b0}};
    rval       = {DATA_WIDTH{1'b0}};
    byp        = 1'b0;
    match      = 1'b0;
    rbusy      = 1'b0;
    force_zero = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      raddr = address[i*ADDR_WIDTH +: ADDR_WIDTH];
      rval  = regs_r[raddr];
      byp   = 1'b0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        match = (BYPASS != 0) && writeEn[j]
              && (addressw[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr);
        byp   = byp | match;
        rval  = match ? writeData[j*DATA_WIDTH +: DATA_WIDTH] : rval;
      end
      rbusy      = busy_r[raddr]
                 & ~(byp & ~(reserveEn && (reserveAddr == raddr)));
      force_zero = !rst_n || is_zero_reg(raddr);
      read[i*DATA_WIDTH +: DATA_WIDTH] = force_zero ? {DATA_WIDTH{1'b0}} : rval;
      busy[i] = force_zero ? 1'b0 : rbusy;
    end
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, dual-read integer register file in the RISC-V pipeline.
- Generalised in data width, depth, and number of read and write ports.
- Adds three features:
  - optional write-to-read bypass for same-cycle writes,
  - a hard-wired zero register,
  - per-register pending-write scoreboard so decode can detect RAW hazards.
- Sits in the ID stage: read ports feed the ID/EX register, write ports are driven from WB, reserve port is driven by decode at issue.

Parameters:
- DATA_WIDTH, 64, width of each register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (>=1).
- NUM_WRITE, 1, number of write ports (>=1).
- BYPASS, 1, 1 = a read of a register being written this cycle returns the new writeData; 0 = returns the stored value.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  NUM_READ*ADDR_WIDTH  read indices; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- read  output  NUM_READ*DATA_WIDTH  read data; port i is [i*DATA_WIDTH +: DATA_WIDTH].
- busy  output  NUM_READ  port i's register has a reserved, not yet written, result.
- addressw  input  NUM_WRITE*ADDR_WIDTH  write indices.
- writeData  input  NUM_WRITE*DATA_WIDTH  write data.
- writeEn  input  NUM_WRITE  per-port write enable.
- reserveEn  input  1  mark a destination register busy at issue.
- reserveAddr  input  ADDR_WIDTH  register to mark busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0, all busy bits cleared.
  - read outputs therefore 0, busy outputs 0.
  - Deassertion is synchronised externally.
  - Reset mid-operation discards any in-flight write or reserve that cycle.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops plus 2**ADDR_WIDTH busy flops. No RAM macro.
- Write:
  - On rising clk, each port j with writeEn[j]=1 stores writeData[j] into addressw[j]. Latency 1 cycle.
  - Several write ports targeting the same address in one cycle: highest-indexed port wins, deterministically.
- Read:
  - Combinational from address to read, zero latency.
  - With BYPASS=1 and writeEn[j]=1 for addressw[j]==address[i] in the same cycle, read[i] = writeData[j]. Same highest-index-wins priority as the write path.
  - With BYPASS=0, read[i] shows the old value until after the edge.
- Zero register (ZERO_REG=1):
  - address 0 always reads 0 regardless of bypass; writes to 0 are dropped.
  - reserve of 0 is ignored; busy for address 0 is always 0.
  - With ZERO_REG=0, register 0 is ordinary.
- Scoreboard, per register, 2-state (IDLE / PENDING):
  - IDLE -> PENDING on rising clk when reserveEn=1 and reserveAddr selects it.
  - PENDING -> IDLE on rising clk when any writeEn[j]=1 with addressw[j] selecting it.
  - Write and reserve of the same register in the same cycle: reserve wins, register stays/becomes PENDING. The write completes an older instruction; the newly issued one still owns it. The data write still happens.
  - Reserve of an already PENDING register: stays PENDING (no counting; the pipeline issues at most one outstanding writer per register).
  - Write to an IDLE register: data written, state stays IDLE.
- Busy output:
  - busy[i] = registered state of address[i], combinational.
  - With BYPASS=1, busy[i] is forced 0 when a same-cycle write to address[i] is bypassed and there is no same-cycle reserve of it. Bypassed data is then valid.
- Width rules:
  - No sign or zero extension; write data is stored exactly.
  - Out-of-range indices are impossible, since depth = 2**ADDR_WIDTH.
- X-safety: with writeEn=0, writeData/addressw values have no effect on state or outputs.

Test Plan:
- Reset/basic, defaults (NUM_READ=2, NUM_WRITE=1):
  - rst_n=0 -> read=0, busy=0.
  - Release; write x1=64'h1234567890ABCDEF, next cycle x2=64'hFEDCBA0987654321; then address={2,1} -> read port0=...CDEF, port1=...4321.
- Zero register: write x0=64'hFFFF_FFFF_FFFF_FFFF with reserveEn=1, reserveAddr=0, then read address 0 -> read=0, busy=0. Repeat with ZERO_REG=0 -> reads all-ones.
- Bypass:
  - BYPASS=1, x5 holds 64'h11; same cycle writeEn=1, addressw=5, writeData=64'h22, address port0=5 -> read=64'h22 before the edge.
  - BYPASS=0 -> read=64'h11 before the edge, 64'h22 after.
- Scoreboard:
  - reserve x7 -> busy for port reading 7 goes 1 one cycle later.
  - Write x7=64'hAB -> busy combinationally 0 that cycle (BYPASS=1), registered 0 after.
  - Same-cycle write+reserve of x7 -> x7=new data and busy stays 1.
- Multi-write conflict (NUM_WRITE=2, NUM_READ=4): both ports write x9 (port0=64'hA, port1=64'hB) -> x9=64'hB. Distinct addresses x3/x4 written in one cycle -> both updated.
- Async reset mid-operation: x1 written, x1 reserved; assert rst_n low between clock edges -> read and busy go 0 immediately, without waiting for clk. A write presented during reset is not stored.
